alu_issue_ctrl: RTL

//  Issue scheduler in front of one PE ALU_unit (6-stage, no stall). Accepts ALU commands on a

---
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue scheduler for one PE ALU_unit: command FIFO, add/sub hazard
// bubbles, credit-limited issue and a result FIFO for stalled consumers.
module alu_issue_ctrl #(
    parameter int D_WIDTH   = 64,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 8,
    parameter int ALU_LAT   = 6,
    parameter int HAZ_DIST  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [4:0]         cmd_opcode,
    input  logic [D_WIDTH-1:0] cmd_in0,
    input  logic [D_WIDTH-1:0] cmd_in1,
    input  logic [D_WIDTH-1:0] cmd_inq,
    output logic               alu_valid,
    output logic [4:0]         alu_opcode,
    output logic [D_WIDTH-1:0] alu_in0,
    output logic [D_WIDTH-1:0] alu_in1,
    output logic [D_WIDTH-1:0] alu_inq,
    input  logic               alu_valid_r,
    input  logic [D_WIDTH-1:0] alu_out0,
    input  logic [D_WIDTH-1:0] alu_out1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [D_WIDTH-1:0] res_out0,
    output logic [D_WIDTH-1:0] res_out1,
    output logic               busy,
    output logic [15:0]        stall_cnt
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int CW  = 5 + 3 * D_WIDTH;
    localparam int RW  = 2 * D_WIDTH;
    localparam logic [RAW+1:0] RES_LIM = (RAW + 2)'(RES_DEPTH);

    logic [CW-1:0]       cmd_mem [CMD_DEPTH];
    logic [CAW:0]        cmd_wp, cmd_rp;
    logic                cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [CW-1:0]       head;
    logic [4:0]          head_op;
    logic                head_early, head_late;
    logic [RW-1:0]       res_mem [RES_DEPTH];
    logic [RAW:0]        res_wp, res_rp, res_count;
    logic                res_empty, res_full, res_pop;
    logic [RAW:0]        inflight;
    logic [HAZ_DIST-1:0] hist;
    logic                credit_ok, issue, drop, stall;

    assign cmd_empty = (cmd_wp == cmd_rp);
    assign cmd_full  = (cmd_wp[CAW] != cmd_rp[CAW]) &&
                       (cmd_wp[CAW-1:0] == cmd_rp[CAW-1:0]);
    assign cmd_ready = !cmd_full;
    assign cmd_push  = cmd_valid && !cmd_full;
    assign head      = cmd_mem[cmd_rp[CAW-1:0]];
    assign head_op   = head[CW-1 -: 5];
    assign head_early = (head_op[3:0] inside {4'd1, 4'd2, 4'd8});
    assign head_late  = (head_op[3:0] inside {4'd5, 4'd6, 4'd7});

    assign res_count = res_wp - res_rp;
    assign res_empty = (res_wp == res_rp);
    assign res_full  = (res_wp[RAW] != res_rp[RAW]) &&
                       (res_wp[RAW-1:0] == res_rp[RAW-1:0]);
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    assign {res_out0, res_out1} = res_mem[res_rp[RAW-1:0]];

    assign credit_ok = ({1'b0, inflight} + {1'b0, res_count}) < RES_LIM;
    assign busy = !cmd_empty || (inflight != '0) || !res_empty;

    // Issue decision: oldest command only; hist top bit is the LATE op
    // that would collide with an EARLY op presented next cycle
    always_comb begin
        issue = 1'b0;
        drop  = 1'b0;
        stall = 1'b0;
        if (!cmd_empty) begin
            if (head_op[3:0] == 4'd0) begin
                drop = 1'b1;
            end else if (credit_ok) begin
                if (head_early && hist[HAZ_DIST-1]) stall = 1'b1;
                else issue = 1'b1;
            end
        end
        cmd_pop = issue || drop;
    end

    // Command storage
    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wp[CAW-1:0]] <= {cmd_opcode, cmd_in0, cmd_in1, cmd_inq};
    end

    // Result storage
    always_ff @(posedge clk) begin
        if (alu_valid_r)
            res_mem[res_wp[RAW-1:0]] <= {alu_out0, alu_out1};
    end

    // Pointers, credit, hazard history and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            res_wp    <= '0;
            res_rp    <= '0;
            inflight  <= '0;
            hist      <= '0;
            stall_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop) cmd_rp <= cmd_rp + 1'b1;
            if (alu_valid_r) res_wp <= res_wp + 1'b1;
            if (res_pop) res_rp <= res_rp + 1'b1;
            if (issue && !alu_valid_r) inflight <= inflight + 1'b1;
            else if (!issue && alu_valid_r) inflight <= inflight - 1'b1;
            hist <= {hist[HAZ_DIST-2:0], issue && head_late};
            if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Registered ALU drive: one-cycle pulse per issue, operands held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid  <= 1'b0;
            alu_opcode <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            alu_inq    <= '0;
        end else if (issue) begin
            alu_valid  <= 1'b1;
            {alu_opcode, alu_in0, alu_in1, alu_inq} <= head;
        end else begin
            alu_valid  <= 1'b0;
            alu_opcode <= '0;
        end
    end

    // Credit must keep the result FIFO from overflowing
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_valid_r && res_full && !res_pop));

endmodule
